// File: rtl/bus_pkg.sv
// Shared bus widths and peripheral FSM state encoding for the 8088-side peripherals.
// Pure declarations: no logic, no timing.
package bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        READ,
        WRITE
    } periph_state_t;

endpackage

// File: rtl/periph_ram.sv
// Byte RAM for one mapped region: synchronous write, registered read (1 clock).
// No flow control; the array is deliberately left unreset.
module periph_ram
    import bus_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 CLK,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_peripheral_ctrl.sv
// Memory/IO peripheral on the demultiplexed 8088 bus: latches/decodes the address, stretches
// the cycle with READY for WAIT_STATES clocks, then serves one byte read or write.
module bus_peripheral_ctrl
    import bus_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE        = '0,
    parameter int                ADDR_BITS   = 12,
    parameter bit                IS_IO       = 1'b0,
    parameter int                WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ALE,
    input  logic              IOM,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] Address,
    inout  wire  [DATA_W-1:0] Data,
    output logic              READY,
    output logic              ERR
);

    localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

    periph_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              iom_q;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_op_q, rd_op_d;
    logic              err_q, err_d;
    logic              wr_done_q;
    logic              hit;
    logic              ram_we;
    logic              drive;
    logic [DATA_W-1:0] rdata;

    assign hit = (iom_q == IS_IO) &&
                 (addr_q[ADDR_W-1:ADDR_BITS] == BASE[ADDR_W-1:ADDR_BITS]);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            iom_q     <= 1'b0;
            cnt_q     <= '0;
            rd_op_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_op_q   <= rd_op_d;
            err_q     <= err_d;
            wr_done_q <= (state_q == WRITE);
            if (ALE) begin
                addr_q <= Address;
                iom_q  <= IOM;
            end
        end
    end

    // ALE takes priority in every state so a new address cycle aborts whatever is pending.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_op_d = rd_op_q;
        err_d   = err_q;
        if (ALE) begin
            state_d = DECODE;
        end else begin
            case (state_q)
                IDLE: ;
                DECODE: begin
                    if (!hit) begin
                        state_d = IDLE;
                    end else if (!RD && !WR) begin
                        err_d = 1'b1;
                    end else if (!RD || !WR) begin
                        rd_op_d = !RD;
                        if (WAIT_STATES > 0) begin
                            state_d = WAIT;
                            cnt_d   = WS_M1;
                        end else begin
                            state_d = !RD ? READ : WRITE;
                        end
                    end
                end
                WAIT: begin
                    if (rd_op_q ? RD : WR) begin
                        state_d = IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_d = rd_op_q ? READ : WRITE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                READ:    if (RD) state_d = IDLE;
                WRITE:   if (WR) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Commit only on the first WRITE clock; the RAM's free-running read register doubles as rdata_q.
    assign ram_we = (state_q == WRITE) && !wr_done_q;

    periph_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (addr_q[ADDR_BITS-1:0]),
        .wdata (Data),
        .rdata (rdata)
    );

    assign drive = !RESET && (state_q == READ) && !RD;
    assign Data  = drive ? rdata : {DATA_W{1'bz}};
    assign READY = RESET || (state_q != WAIT);
    assign ERR   = err_q;

endmodule

// File: tb/tb_bus_peripheral_ctrl.sv
// Four peripherals share one pulled-up bus: u0 mem@0x00000 ws0, u1 mem@0x01000 ws3,
// u2 io@0x10000 ws0, u3 mem@0x02000 ws2.
module tb_bus_peripheral_ctrl;

    logic        clk = 1'b0;
    logic        rst, ale, iom, rd_n, wr_n, drv_en;
    logic [19:0] addr;
    logic [7:0]  drv_dat;
    logic [3:0]  rdy, err;
    wire  [7:0]  data_bus;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign data_bus = drv_en ? drv_dat : 8'hzz;
    pullup pu_bus (data_bus);

    bus_peripheral_ctrl #(.BASE(20'h00000), .ADDR_BITS(12), .IS_IO(1'b0), .WAIT_STATES(0)) u0 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(rdy[0]), .ERR(err[0]));
    bus_peripheral_ctrl #(.BASE(20'h01000), .ADDR_BITS(12), .IS_IO(1'b0), .WAIT_STATES(3)) u1 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(rdy[1]), .ERR(err[1]));
    bus_peripheral_ctrl #(.BASE(20'h10000), .ADDR_BITS(12), .IS_IO(1'b1), .WAIT_STATES(0)) u2 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(rdy[2]), .ERR(err[2]));
    bus_peripheral_ctrl #(.BASE(20'h02000), .ADDR_BITS(12), .IS_IO(1'b0), .WAIT_STATES(2)) u3 (
        .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd_n), .WR(wr_n),
        .Address(addr), .Data(data_bus), .READY(rdy[3]), .ERR(err[3]));

    typedef struct {
        logic        wr;
        logic        io;
        logic [19:0] a;
        logic [7:0]  d;
        logic        hit;
        int          ws;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic wr, input logic io, input logic [19:0] a,
                                input logic [7:0] d, input logic hit, input int ws);
        vec_t v;
        v.wr = wr; v.io = io; v.a = a; v.d = d; v.hit = hit; v.ws = ws;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_access(input int idx, input vec_t v);
        logic [7:0] smp [8];
        int         lows;
        int         bad;
        @(negedge clk);
        addr = v.a; iom = v.io; ale = 1'b1;
        @(negedge clk);
        ale = 1'b0;
        if (v.wr) begin
            wr_n = 1'b0; drv_en = 1'b1; drv_dat = v.d;
        end else begin
            rd_n = 1'b0;
        end
        #1 smp[0] = data_bus;
        lows = 0;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            smp[k] = data_bus;
            if (rdy != 4'hF) lows++;
        end
        check($sformatf("v%0d ready_low_cycles", idx), lows, v.ws);
        if (!v.wr) begin
            if (v.hit) begin
                check($sformatf("v%0d bus_before_valid", idx), smp[v.ws], 8'hFF);
                check($sformatf("v%0d rdata", idx), smp[v.ws + 1], v.d);
            end else begin
                bad = 0;
                for (int k = 0; k < 8; k++) if (smp[k] != 8'hFF) bad++;
                check($sformatf("v%0d miss_driven_cycles", idx), bad, 0);
            end
        end
        rd_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
        #1;
        check($sformatf("v%0d bus_released", idx), data_bus, 8'hFF);
        check($sformatf("v%0d ready_after", idx), rdy, 4'hF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ale = 1'b0; iom = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
        addr = '0; drv_en = 1'b0; drv_dat = '0;
        repeat (2) @(negedge clk);
        check("reset ready", rdy, 4'hF);
        check("reset err", err, 4'h0);
        check("reset bus", data_bus, 8'hFF);
        rst = 1'b0;

        vt[0]  = mk(1, 0, 20'h00010, 8'hA5, 1, 0);
        vt[1]  = mk(0, 0, 20'h00010, 8'hA5, 1, 0);
        vt[2]  = mk(1, 0, 20'h01020, 8'h3C, 1, 3);
        vt[3]  = mk(0, 0, 20'h01020, 8'h3C, 1, 3);
        vt[4]  = mk(1, 1, 20'h10010, 8'h5A, 1, 0);
        vt[5]  = mk(0, 1, 20'h10010, 8'h5A, 1, 0);
        vt[6]  = mk(1, 1, 20'h20010, 8'h99, 0, 0);
        vt[7]  = mk(0, 1, 20'h20010, 8'h00, 0, 0);
        vt[8]  = mk(1, 0, 20'h10010, 8'h77, 0, 0);
        vt[9]  = mk(0, 0, 20'h10010, 8'h00, 0, 0);
        vt[10] = mk(0, 1, 20'h10010, 8'h5A, 1, 0);
        vt[11] = mk(0, 0, 20'h00010, 8'hA5, 1, 0);
        vt[12] = mk(1, 0, 20'h01FFF, 8'hE7, 1, 3);
        vt[13] = mk(0, 0, 20'h01FFF, 8'hE7, 1, 3);
        vt[14] = mk(1, 0, 20'h02004, 8'hC3, 1, 2);
        vt[15] = mk(0, 0, 20'h02004, 8'hC3, 1, 2);
        vt[16] = mk(1, 0, 20'h02008, 8'h22, 1, 2);
        vt[17] = mk(1, 0, 20'h01040, 8'h66, 1, 3);
        vt[18] = mk(1, 0, 20'h01030, 8'h55, 1, 3);
        vt[19] = mk(1, 0, 20'h00050, 8'h12, 1, 0);
        vt[20] = mk(0, 0, 20'h00FFF, 8'h00, 0, 0);
        // vt[20] reads an unwritten u0 byte; only the first 20 run in the loop
        for (int i = 0; i < 20; i++) run_access(i, vt[i]);

        // Reset while a read on u3 is waiting.
        @(negedge clk); addr = 20'h02004; iom = 1'b0; ale = 1'b1;
        @(negedge clk); ale = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        check("rst_wait ready_low", rdy[3], 1'b0);
        rst = 1'b1;
        #1;
        check("rst_wait ready", rdy, 4'hF);
        check("rst_wait bus", data_bus, 8'hFF);
        @(negedge clk); rst = 1'b0; rd_n = 1'b1;
        run_access(100, mk(0, 0, 20'h02004, 8'hC3, 1, 2));

        // Reset during a waiting write: the old byte must survive.
        @(negedge clk); addr = 20'h02008; ale = 1'b1;
        @(negedge clk); ale = 1'b0; wr_n = 1'b0; drv_en = 1'b1; drv_dat = 8'h11;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; wr_n = 1'b1; drv_en = 1'b0;
        run_access(101, mk(0, 0, 20'h02008, 8'h22, 1, 2));

        // Reset while u0 is actively driving a read.
        @(negedge clk); addr = 20'h00010; ale = 1'b1;
        @(negedge clk); ale = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        check("rst_read driving", data_bus, 8'hA5);
        rst = 1'b1;
        #1;
        check("rst_read bus", data_bus, 8'hFF);
        check("rst_read ready", rdy, 4'hF);
        @(negedge clk); rst = 1'b0; rd_n = 1'b1;

        // New ALE during u1's wait window, WR held low throughout.
        @(negedge clk); addr = 20'h01040; ale = 1'b1;
        @(negedge clk); ale = 1'b0; wr_n = 1'b0; drv_en = 1'b1; drv_dat = 8'h44;
        repeat (2) @(negedge clk);
        check("abort wait ready", rdy[1], 1'b0);
        addr = 20'h00030; ale = 1'b1; drv_dat = 8'h88;
        @(negedge clk); ale = 1'b0;
        check("abort ready_after_ale", rdy, 4'hF);
        repeat (3) @(negedge clk);
        check("abort ready_during_new", rdy, 4'hF);
        wr_n = 1'b1; drv_en = 1'b0;
        run_access(102, mk(0, 0, 20'h01040, 8'h66, 1, 3));
        run_access(103, mk(0, 0, 20'h01030, 8'h55, 1, 3));
        run_access(104, mk(0, 0, 20'h00030, 8'h88, 1, 0));

        // Both strobes low on a hit: sticky ERR and no access.
        @(negedge clk); addr = 20'h00050; ale = 1'b1;
        @(negedge clk); ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0; drv_en = 1'b1; drv_dat = 8'hEE;
        repeat (2) @(negedge clk);
        check("err set", err, 4'b0001);
        check("err ready", rdy, 4'hF);
        rd_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
        run_access(105, mk(0, 0, 20'h00050, 8'h12, 1, 0));
        check("err sticky", err, 4'b0001);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("err cleared", err, 4'h0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
